mf8_uart_tx: RTL
================

Name: mf8_uart_tx

Overview:
- Hardware UART transmitter on the mf8 core's IO bus. Replaces the software bit-banged TXD register.
- The core writes bytes into a small FIFO. The block serialises them as 8N1 frames on UART_TXD at a programmable baud divisor.
- Status and divisor are readable over IO_RData. Output is zero when not addressed, so it can be OR-merged with other IO slaves.

Parameters:
- BASE_ADDR, 6'h00, IO address of the DATA/STATUS register. DIVL is BASE_ADDR+1, DIVH is BASE_ADDR+2.
- FIFO_DEPTH, 4, TX FIFO entries. Must be a power of 2, range 2..16.
- DIV_RESET, 16'd433, divisor after reset. Bit period is DIV+1 clocks.

Ports:
- Clk  input  1  system clock
- Reset_n  input  1  asynchronous active-low reset
- IO_Addr  input  6  IO register address from core
- IO_Wr  input  1  IO write strobe, one cycle per access
- IO_Rd  input  1  IO read strobe
- IO_WData  input  8  IO write data
- IO_RData  output  8  read data; 8'h00 unless IO_Rd=1 and address hits this block
- UART_TXD  output  1  serial output, idle high
- tx_irq  output  1  high while the FIFO is empty and the shifter is idle

Behaviour:
- Reset (async, Reset_n=0): UART_TXD=1, FSM=IDLE, FIFO emptied, overrun=0, DIV=DIV_RESET, tx_irq=1. Applies immediately, including mid-frame; the frame is aborted without a stop bit.
- Register map:
  - BASE+0 write: push IO_WData.
  - BASE+0 read: STATUS = {4'b0, overrun, empty, full, busy}.
  - BASE+1: DIV[7:0], read/write.
  - BASE+2: DIV[15:8], read/write.
  - Other addresses: ignored.
- IO_RData is combinational from IO_Addr/IO_Rd, with no wait states.
- Reading STATUS clears overrun on that clock edge; the read itself returns the pre-clear value.
- Push:
  - On an edge with IO_Wr=1 and addr=BASE, the byte is written if count<FIFO_DEPTH (count sampled before the edge).
  - Otherwise the byte is dropped and overrun is set.
  - When count==FIFO_DEPTH, the push is dropped even if a pop occurs on the same edge.
  - A push and a pop on the same edge with count<FIFO_DEPTH leave count unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
- FSM states: IDLE, START, DATA, STOP. A bit counter bitcnt (3b) and a baud counter baudcnt (16b) count down.
  - IDLE: TXD=1. If count!=0: pop to shift register, TXD<=0, baudcnt<=DIV, go to START. Latency: TXD falls one clock after the edge that captured the write.
  - START: when baudcnt==0, TXD<=shreg[0], bitcnt<=0, baudcnt<=DIV, go to DATA. Otherwise decrement baudcnt.
  - DATA: when baudcnt==0, either shift right and TXD<=next bit, or, if bitcnt==7, TXD<=1 and go to STOP. Always reload baudcnt<=DIV. Data is LSB first.
  - STOP: when baudcnt==0, go to IDLE. A queued byte starts its start bit on the next edge, giving back-to-back frames with exactly 1 stop bit plus 1 clock of gap.
- Each bit lasts exactly DIV+1 clocks, so a frame lasts 10*(DIV+1) clocks, plus 1 idle clock between frames.
- DIV written mid-frame: takes effect at the next baudcnt reload; the current bit is unaffected. DIV=0 gives 1 clock/bit and must work.
- Status bits:
  - busy = FSM!=IDLE.
  - empty = count==0.
  - full = count==FIFO_DEPTH.
  - tx_irq = empty & ~busy, registered.

Test Plan:
- Reset, then read STATUS -> 8'h04; read DIVL/DIVH -> 8'hB1/8'h01; UART_TXD=1.
- Write DIV=3, push 8'hA5 -> TXD low 1 clock after the write. Bits 0,1,0,1,0,0,1,0,1,1, each 4 clocks (40-clock frame). busy=1 throughout. tx_irq rises after the stop bit.
- DIV=0, push 8'h00, 8'hFF back-to-back -> frames 0,00000000,1 then 1 idle clock, then 0,11111111,1; 21 clocks total.
- DIV=15, push 5 bytes with FIFO_DEPTH=4 while TX is stalled. The 1st byte pops immediately, so 4 are stored, and the 6th push sets overrun (STATUS=8'h0B). A second STATUS read returns 8'h03.
- Push 8'h3C with DIV=7. Write DIV=1 during data bit 2 -> bit 2 remains 8 clocks; bits 3 onward are 2 clocks each.
- Assert Reset_n mid-data-bit -> UART_TXD=1 asynchronously; FIFO empty, DIV back to 433. After release, no residual frame is sent.

Source files
------------

// File: rtl/mf8_uart_tx.sv
// mf8 IO-bus UART transmitter: byte FIFO feeding an 8N1 serialiser with a
// programmable 16-bit baud divisor (bit period = DIV+1 clocks).
module mf8_uart_tx #(
  parameter logic [5:0]  BASE_ADDR  = 6'h00,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [5:0] IO_Addr,
  input  logic       IO_Wr,
  input  logic       IO_Rd,
  input  logic [7:0] IO_WData,
  output logic [7:0] IO_RData,
  output logic       UART_TXD,
  output logic       tx_irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [5:0]    ADDR_DIVL = BASE_ADDR + 6'd1;
  localparam logic [5:0]    ADDR_DIVH = BASE_ADDR + 6'd2;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q;
  logic [15:0]   div_q;
  logic          txd_q, txd_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [15:0]   baudcnt_q, baudcnt_d;
  logic          tx_irq_q;

  logic sel_data, push_req, push_ok, pop, full, empty, busy, stat_rd, baud_zero;

  assign sel_data  = (IO_Addr == BASE_ADDR);
  assign push_req  = IO_Wr & sel_data;
  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign busy      = (state_q != S_IDLE);
  assign push_ok   = push_req & ~full;
  assign pop       = (state_q == S_IDLE) & ~empty;
  assign stat_rd   = IO_Rd & sel_data;
  assign baud_zero = (baudcnt_q == 16'd0);

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      div_q     <= DIV_RESET;
    end else begin
      count_q <= count_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
      // A dropped push wins over a same-edge STATUS read so no overrun is lost.
      if (push_req && full) overrun_q <= 1'b1;
      else if (stat_rd)     overrun_q <= 1'b0;
      if (IO_Wr && IO_Addr == ADDR_DIVL) div_q[7:0]  <= IO_WData;
      if (IO_Wr && IO_Addr == ADDR_DIVH) div_q[15:8] <= IO_WData;
    end
  end

  always_ff @(posedge Clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= IO_WData;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!empty)   state_d = S_START;
      S_START: if (baud_zero) state_d = S_DATA;
      S_DATA:  if (baud_zero && bitcnt_q == 3'd7) state_d = S_STOP;
      S_STOP:  if (baud_zero) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    txd_d     = txd_q;
    shreg_d   = shreg_q;
    bitcnt_d  = bitcnt_q;
    baudcnt_d = baudcnt_q;
    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (!empty) begin
          shreg_d   = mem_q[rd_ptr_q];
          txd_d     = 1'b0;
          baudcnt_d = div_q;
        end
      end
      S_START: begin
        if (baud_zero) begin
          txd_d     = shreg_q[0];
          bitcnt_d  = 3'd0;
          baudcnt_d = div_q;
        end else begin
          baudcnt_d = baudcnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (baud_zero) begin
          baudcnt_d = div_q;
          if (bitcnt_q == 3'd7) begin
            txd_d = 1'b1;
          end else begin
            shreg_d  = shreg_q >> 1;
            txd_d    = shreg_q[1];
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end else begin
          baudcnt_d = baudcnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (!baud_zero) baudcnt_d = baudcnt_q - 16'd1;
      end
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      txd_q     <= 1'b1;
      bitcnt_q  <= 3'd0;
      baudcnt_q <= 16'd0;
      tx_irq_q  <= 1'b1;
    end else begin
      txd_q     <= txd_d;
      bitcnt_q  <= bitcnt_d;
      baudcnt_q <= baudcnt_d;
      tx_irq_q  <= (count_d == '0) && (state_d == S_IDLE);
    end
  end

  always_ff @(posedge Clk) begin
    shreg_q <= shreg_d;
  end

  // Zero when not addressed so several IO slaves can be OR-merged.
  always_comb begin
    IO_RData = 8'h00;
    if (IO_Rd) begin
      if (IO_Addr == BASE_ADDR)      IO_RData = {4'b0, overrun_q, empty, full, busy};
      else if (IO_Addr == ADDR_DIVL) IO_RData = div_q[7:0];
      else if (IO_Addr == ADDR_DIVH) IO_RData = div_q[15:8];
    end
  end

  assign UART_TXD = txd_q;
  assign tx_irq   = tx_irq_q;

endmodule
